// File: rtl/player_bullet_ctrl_pkg.sv
// rtl/player_bullet_ctrl_pkg.sv - shared game constants and bullet state encoding
package player_bullet_ctrl_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int COORD_W  = 10;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLYING   = 2'd1,
        COOLDOWN = 2'd2
    } bullet_state_t;

endpackage

// File: rtl/player_bullet_ctrl_edge.sv
// rtl/player_bullet_ctrl_edge.sv - one-flop rising-edge detector for synchronised buttons
module edge_detect_rise (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic din_q;
    logic din_d;

    always_comb begin
        din_d = din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            din_q <= 1'b0;
        end else begin
            din_q <= din_d;
        end
    end

    assign rise = din & ~din_q;

endmodule

// File: rtl/player_bullet_ctrl.sv
// rtl/player_bullet_ctrl.sv - single player bullet: launch on fire, climb per move_tick, retire on hit or top exit
module player_bullet_ctrl #(
    parameter int BULLET_SPEED   = 4,
    parameter int X_OFFSET       = 20,
    parameter int LAUNCH_DY      = 10,
    parameter int COOLDOWN_TICKS = 8,
    parameter int SCREEN_W       = player_bullet_ctrl_pkg::SCREEN_W
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   move_tick,
    input  logic                                   fire,
    input  logic [player_bullet_ctrl_pkg::COORD_W-1:0] player_x,
    input  logic [player_bullet_ctrl_pkg::COORD_W-1:0] player_y,
    input  logic                                   hit,
    output logic [player_bullet_ctrl_pkg::COORD_W-1:0] b_x,
    output logic [player_bullet_ctrl_pkg::COORD_W-1:0] b_y,
    output logic                                   bullet_en,
    output logic                                   shot
);

    import player_bullet_ctrl_pkg::*;

    localparam int CNT_W = (COOLDOWN_TICKS < 1) ? 1 : $clog2(COOLDOWN_TICKS + 1);

    localparam logic [COORD_W:0]   X_MAX     = (COORD_W + 1)'(SCREEN_W - 1);
    localparam logic [COORD_W:0]   X_OFF     = (COORD_W + 1)'(X_OFFSET);
    localparam logic [COORD_W-1:0] DY        = COORD_W'(LAUNCH_DY);
    localparam logic [COORD_W-1:0] SPEED     = COORD_W'(BULLET_SPEED);
    localparam logic [CNT_W-1:0]   CNT_RELOAD = CNT_W'(COOLDOWN_TICKS);

    bullet_state_t      state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [COORD_W-1:0] b_x_q, b_x_d;
    logic [COORD_W-1:0] b_y_q, b_y_d;
    logic               bullet_en_q, bullet_en_d;
    logic               shot_q, shot_d;

    logic               fire_rise;
    logic [COORD_W:0]   launch_x_wide;
    logic [COORD_W-1:0] launch_x;
    logic [COORD_W-1:0] launch_y;

    edge_detect_rise u_fire_edge (
        .clk  (clk),
        .rst  (rst),
        .din  (fire),
        .rise (fire_rise)
    );

    // One extra bit on the x sum so a nose past the right edge clamps instead of wrapping.
    always_comb begin
        launch_x_wide = {1'b0, player_x} + X_OFF;
        launch_x      = (launch_x_wide > X_MAX) ? X_MAX[COORD_W-1:0] : launch_x_wide[COORD_W-1:0];
        launch_y      = (player_y < DY) ? '0 : player_y - DY;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        b_x_d       = b_x_q;
        b_y_d       = b_y_q;
        bullet_en_d = bullet_en_q;
        shot_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (fire_rise) begin
                    b_x_d       = launch_x;
                    b_y_d       = launch_y;
                    bullet_en_d = 1'b1;
                    shot_d      = 1'b1;
                    state_d     = FLYING;
                end
            end
            FLYING: begin
                // A hit wins over a simultaneous move so b_y freezes where the judge saw it.
                if (hit || (move_tick && (b_y_q < SPEED))) begin
                    bullet_en_d = 1'b0;
                    cnt_d       = CNT_RELOAD;
                    state_d     = COOLDOWN;
                end else if (move_tick) begin
                    b_y_d = b_y_q - SPEED;
                end
            end
            COOLDOWN: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else if (move_tick) begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                bullet_en_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            b_x_q       <= '0;
            b_y_q       <= '0;
            bullet_en_q <= 1'b0;
            shot_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            b_x_q       <= b_x_d;
            b_y_q       <= b_y_d;
            bullet_en_q <= bullet_en_d;
            shot_q      <= shot_d;
        end
    end

    assign b_x       = b_x_q;
    assign b_y       = b_y_q;
    assign bullet_en = bullet_en_q;
    assign shot      = shot_q;

endmodule

// File: tb/tb_player_bullet_ctrl.sv
// tb/tb_player_bullet_ctrl.sv - scoreboard bench for player_bullet_ctrl against a behavioural bullet model
module tb_player_bullet_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       move_tick = 1'b0;
    logic       fire = 1'b0;
    logic [9:0] player_x = '0;
    logic [9:0] player_y = '0;
    logic       hit = 1'b0;
    logic [9:0] b_x;
    logic [9:0] b_y;
    logic       bullet_en;
    logic       shot;

    always #5 clk = ~clk;

    player_bullet_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .move_tick (move_tick),
        .fire      (fire),
        .player_x  (player_x),
        .player_y  (player_y),
        .hit       (hit),
        .b_x       (b_x),
        .b_y       (b_y),
        .bullet_en (bullet_en),
        .shot      (shot)
    );

    typedef struct {
        logic       en;
        logic [9:0] x;
        logic [9:0] y;
        logic       shot;
        int         seq;
    } exp_t;

    exp_t exp_q[$];

    int n_cmp = 0;
    int n_err = 0;
    int seq_no = 0;

    // Behavioural model: "is there a bullet, where is it, how many ticks until the gun is ready"
    bit m_alive;
    bit m_cooling;
    int m_cool_left;
    int m_x;
    int m_y;
    bit m_prev_fire;

    task automatic check(input string name, input int act, input int exp_v, input int seq);
        n_cmp++;
        if (act != exp_v) begin
            n_err++;
            $display("FAIL %s step=%0d actual=%0d required=%0d", name, seq, act, exp_v);
        end
    endtask

    task automatic model_reset();
        m_alive     = 0;
        m_cooling   = 0;
        m_cool_left = 0;
        m_x         = 0;
        m_y         = 0;
        m_prev_fire = 0;
    endtask

    task automatic step(input bit f, input bit t, input bit h, input int px, input int py);
        exp_t e;
        bit   pressed;
        bit   launched;
        @(negedge clk);
        fire      = f;
        move_tick = t;
        hit       = h;
        player_x  = 10'(px);
        player_y  = 10'(py);

        pressed     = f && !m_prev_fire;
        m_prev_fire = f;
        launched    = 0;
        if (m_alive) begin
            if (h || (t && m_y < 4)) begin
                m_alive     = 0;
                m_cooling   = 1;
                m_cool_left = 8;
            end else if (t) begin
                m_y = m_y - 4;
            end
        end else if (m_cooling) begin
            if (m_cool_left == 0) m_cooling = 0;
            else if (t) m_cool_left = m_cool_left - 1;
        end else if (pressed) begin
            m_x      = (px + 20 > 639) ? 639 : px + 20;
            m_y      = (py < 10) ? 0 : py - 10;
            m_alive  = 1;
            launched = 1;
        end

        e.en   = m_alive;
        e.x    = 10'(m_x);
        e.y    = 10'(m_y);
        e.shot = launched;
        e.seq  = seq_no++;
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("bullet_en", int'(bullet_en), int'(e.en), e.seq);
                check("b_x", int'(b_x), int'(e.x), e.seq);
                check("b_y", int'(b_y), int'(e.y), e.seq);
                check("shot", int'(shot), int'(e.shot), e.seq);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        n_cmp++;
        n_err++;
        $display("FAIL watchdog simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        bit rf;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_en", int'(bullet_en), 0, -1);
        check("reset_bx", int'(b_x), 0, -1);
        check("reset_by", int'(b_y), 0, -1);
        check("reset_shot", int'(shot), 0, -1);
        @(negedge clk);
        rst = 1'b0;

        step(0, 0, 0, 300, 400);
        step(1, 0, 0, 300, 400);
        for (int i = 0; i < 6; i++) step(1, (i % 2) == 1, 0, 300, 400);
        for (int i = 0; i < 110; i++) step(1, 1, 0, 300, 400);
        for (int i = 0; i < 12; i++) step((i % 2) == 0, 1, 0, 100, 100);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 100, 100);

        step(1, 0, 0, 50, 13);
        step(0, 1, 0, 50, 13);
        for (int i = 0; i < 20; i++) step((i % 3) == 0, (i % 2) == 0, 0, 50, 13);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0);

        step(1, 0, 0, 100, 210);
        step(0, 1, 1, 100, 210);
        step(0, 1, 1, 100, 210);
        for (int i = 0; i < 14; i++) step(0, 1, 0, 0, 0);

        step(1, 0, 0, 630, 5);
        step(0, 0, 0, 630, 5);
        step(0, 1, 0, 630, 5);
        for (int i = 0; i < 14; i++) step(0, 1, 0, 0, 0);

        step(1, 0, 0, 200, 300);
        step(0, 1, 0, 200, 300);
        step(0, 0, 0, 200, 300);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_en", int'(bullet_en), 0, seq_no);
        check("async_rst_bx", int'(b_x), 0, seq_no);
        check("async_rst_by", int'(b_y), 0, seq_no);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        step(1, 0, 0, 400, 200);
        step(0, 1, 0, 400, 200);

        rf = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) rf = ~rf;
            step(rf, $urandom_range(0, 2) == 0, $urandom_range(0, 11) == 0,
                 int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
        end

        repeat (3) @(posedge clk);
        #2;
        check("queue_drained", exp_q.size(), 0, seq_no);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/player_bullet_ctrl.md
Name: player_bullet_ctrl

Overview:
Owns the single player bullet: launches it from the player plane on a fire press, moves it upward once per game tick, and retires it on a hit or when it leaves the top of the screen. Feeds b_x, b_y and the bullet-exists flag to the enemy hit/boom judge. Consumes that judge's hit indication, which is its bullet-still-exists output inverted.

Parameters:
BULLET_SPEED, 4, pixels subtracted from b_y per move_tick
X_OFFSET, 20, launch x offset from player_x (bullet centred on plane nose)
LAUNCH_DY, 10, launch y offset above player_y
COOLDOWN_TICKS, 8, move_ticks after retirement before next fire is accepted
SCREEN_W, 640, horizontal limit; launch x saturates at SCREEN_W-1

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
move_tick  in  1  one-cycle pulse per game movement step
fire  in  1  fire button level, already synchronised to clk
player_x  in  10  player plane x
player_y  in  10  player plane y
hit  in  1  1 = judge consumed the bullet this cycle
b_x  out  10  bullet x
b_y  out  10  bullet y
bullet_en  out  1  1 = bullet exists
shot  out  1  one-cycle pulse on launch (sound/score hooks)

Behaviour:
- Reset (async, rst=1):
  - bullet_en=0, b_x=0, b_y=0, shot=0
  - state=IDLE, cooldown counter=0, fire_q=0
- Fire edge: fire_rise = fire & ~fire_q. fire_q is registered every cycle. A held button fires once only.
- States: IDLE, FLYING, COOLDOWN.
- IDLE, on fire_rise (1 cycle latency):
  - b_x <= min(player_x+X_OFFSET, SCREEN_W-1), using 11-bit intermediate
  - b_y <= player_y-LAUNCH_DY, saturating at 0
  - bullet_en<=1, shot<=1 for that one cycle
  - state -> FLYING
- FLYING:
  - hit=1 (priority over move_tick): bullet_en<=0, cnt<=COOLDOWN_TICKS, state -> COOLDOWN.
  - Otherwise, on move_tick with b_y<BULLET_SPEED: bullet_en<=0, cnt<=COOLDOWN_TICKS, state -> COOLDOWN. This is the top-exit retirement; no underflow wrap.
  - Otherwise, on move_tick: b_y <= b_y-BULLET_SPEED.
  - b_x is held constant while FLYING.
  - fire_rise is ignored.
- COOLDOWN:
  - cnt==0 -> IDLE on the next cycle. COOLDOWN_TICKS=0 therefore gives a single-cycle COOLDOWN.
  - Otherwise cnt decrements on move_tick.
  - fire_rise is ignored and not queued.
- b_x/b_y hold their last values after retirement. Consumers qualify them with bullet_en.
- hit while not FLYING: ignored.
- fire_rise and move_tick in the same IDLE cycle: launch only. The first move happens on the next move_tick.
- rst mid-flight: bullet is removed immediately (asynchronous), all state cleared.
- All outputs are registered; no combinational path from input to output.

Decomposition:
- Shared game package holds:
  - screen constants SCREEN_W=640, SCREEN_H=480
  - coordinate width COORD_W=10
  - bullet state enum {IDLE, FLYING, COOLDOWN}
- The same package is reused by the judge and the enemy movers.
- One natural sub-module: edge_detect_rise, a one-flop rising-edge detector with async reset. It is reusable for other buttons.

Test Plan:
- Reset, then fire 0->1 with player_x=300, player_y=400 -> next cycle: bullet_en=1, b_x=320, b_y=390, shot=1 for exactly one cycle.
- Flying with b_y=390, three move_ticks -> b_y=378. Hold fire high throughout -> no second launch, shot stays 0.
- b_y=3 and move_tick -> bullet_en=0, state COOLDOWN. Fire press during the next 8 move_ticks -> ignored. After cnt reaches 0 and state returns to IDLE, fire press -> launch.
- Flying with b_y=200, hit and move_tick asserted in the same cycle -> bullet_en=0, b_y stays 200, state COOLDOWN.
- player_x=630, player_y=5, fire -> b_x=639, b_y=0. The next move_tick retires the bullet.
- rst pulsed asynchronously mid-flight (between clk edges) -> bullet_en=0, b_x=0, b_y=0 before the next clk edge. Fire after reset release -> normal launch.
